sv_trigger_sequencer: RTL

- Sequencing controller for the camera trigger path.
- Latches a trigger configuration on arm, selects one event source (external edge, divided encoder steps, or internal periodic timer), and emits fixed-width trigger pulses.
- Enforces a holdoff between triggers and stops after a programmed count.
- Sits between the register/control interface and the downstream trigger output; reports busy, done, issued count and dropped-event count.

---
 rtl/sv_trigger_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sv_trigger_sequencer.sv
// Camera trigger sequencer: arms on request, turns one event source into fixed-width pulses
// with holdoff and a trigger budget. Optional software force input under TRIG_SW_FORCE_EN.
module sv_trigger_sequencer #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic [1:0]       i_src_sel,
    input  logic             i_ext_edge,
    input  logic             i_enc_step,
    input  logic [CNT_W-1:0] i_enc_div,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_holdoff,
    input  logic [CNT_W-1:0] i_num_trig,
`ifdef TRIG_SW_FORCE_EN
    input  logic             i_force,
`endif
    output logic             o_trigger,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_trig_cnt,
    output logic [CNT_W-1:0] o_missed_cnt
);

    localparam int unsigned PULSE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPulse,
        StHoldoff
    } state_e;

    state_e state_q, state_d;

    // Shadow configuration, captured on arm.
    logic [1:0]       src_q;
    logic [CNT_W-1:0] enc_div_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] holdoff_q;
    logic [CNT_W-1:0] num_trig_q;
    logic             latch_cfg;

    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   tmr_cnt_q, tmr_cnt_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0]   missed_cnt_q, missed_cnt_d;
    logic               trigger_q;
    logic               done_q, done_d;

    logic [CNT_W-1:0] enc_div_eff;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] missed_inc;
    logic             src_evt;
    logic             evt;

    assign enc_div_eff = (enc_div_q == '0) ? CNT_W'(1) : enc_div_q;
    assign period_eff  = (period_q == '0) ? CNT_W'(1) : period_q;
    assign missed_inc  = (missed_cnt_q == '1) ? missed_cnt_q : missed_cnt_q + CNT_W'(1);

    // Event sources; divider and timer sit at zero while idle so each arm starts clean.
    always_comb begin
        src_evt   = 1'b0;
        div_cnt_d = div_cnt_q;
        tmr_cnt_d = tmr_cnt_q;
        if (state_q == StIdle) begin
            div_cnt_d = '0;
            tmr_cnt_d = '0;
        end else begin
            unique case (src_q)
                2'd0: src_evt = i_ext_edge;
                2'd1: begin
                    if (i_enc_step) begin
                        if (div_cnt_q == enc_div_eff - CNT_W'(1)) begin
                            src_evt   = 1'b1;
                            div_cnt_d = '0;
                        end else begin
                            div_cnt_d = div_cnt_q + CNT_W'(1);
                        end
                    end
                end
                2'd2: begin
                    if (tmr_cnt_q == period_eff - CNT_W'(1)) begin
                        src_evt   = 1'b1;
                        tmr_cnt_d = '0;
                    end else begin
                        tmr_cnt_d = tmr_cnt_q + CNT_W'(1);
                    end
                end
                default: src_evt = 1'b0;
            endcase
        end
    end

`ifdef TRIG_SW_FORCE_EN
    assign evt = src_evt | i_force;
`else
    assign evt = src_evt;
`endif

    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        trig_cnt_d   = trig_cnt_q;
        missed_cnt_d = missed_cnt_q;
        done_d       = 1'b0;
        latch_cfg    = 1'b0;
        if (state_q != StIdle && i_abort) begin
            // Counters keep their values so software can read back a stopped sequence.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_arm && !i_abort) begin
                        latch_cfg    = 1'b1;
                        trig_cnt_d   = '0;
                        missed_cnt_d = '0;
                        state_d      = StArmed;
                    end
                end
                StArmed: begin
                    if (evt) begin
                        state_d     = StPulse;
                        pulse_cnt_d = '0;
                        trig_cnt_d  = trig_cnt_q + CNT_W'(1);
                    end
                end
                StPulse: begin
                    if (evt) begin
                        missed_cnt_d = missed_inc;
                    end
                    if (pulse_cnt_q == PULSE_LAST) begin
                        if (num_trig_q != '0 && trig_cnt_q == num_trig_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (holdoff_q == '0) begin
                            state_d = StArmed;
                        end else begin
                            state_d    = StHoldoff;
                            hold_cnt_d = '0;
                        end
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                    end
                end
                StHoldoff: begin
                    if (evt) begin
                        missed_cnt_d = missed_inc;
                    end
                    if (hold_cnt_q == holdoff_q - CNT_W'(1)) begin
                        state_d = StArmed;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q      <= StIdle;
            src_q        <= '0;
            enc_div_q    <= '0;
            period_q     <= '0;
            holdoff_q    <= '0;
            num_trig_q   <= '0;
            div_cnt_q    <= '0;
            tmr_cnt_q    <= '0;
            pulse_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            trig_cnt_q   <= '0;
            missed_cnt_q <= '0;
            trigger_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            tmr_cnt_q    <= tmr_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            trig_cnt_q   <= trig_cnt_d;
            missed_cnt_q <= missed_cnt_d;
            trigger_q    <= (state_d == StPulse);
            done_q       <= done_d;
            if (latch_cfg) begin
                src_q      <= i_src_sel;
                enc_div_q  <= i_enc_div;
                period_q   <= i_period;
                holdoff_q  <= i_holdoff;
                num_trig_q <= i_num_trig;
            end
        end
    end

    assign o_trigger    = trigger_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_trig_cnt   = trig_cnt_q;
    assign o_missed_cnt = missed_cnt_q;

endmodule
